// File: rtl/ifu_pkg.sv
// Shared types and constants for the prefetching instruction fetch unit.
package ifu_pkg;

  // Fetch engine states: issue decision, address phase, data phase, stopped on bus fault.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HALT = 2'd3
  } ifu_state_e;

  // AXI read response codes.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Queue entry layout at the default 32-bit widths; the top packs entries in the
  // same field order (pc, inst, fault) for any width.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } ifu_entry_t;

  // Anything other than OKAY is treated as a fetch fault.
  function automatic logic resp_is_fault(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Synchronous prefetch queue with push/pop and a flush that overrides both.
module ifu_fetch_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & (count != '0);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; the producer guarantees a push never meets a full queue.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ifu_prefetch_axi.sv
// Instruction fetch unit: sequential AXI-Lite fetches into a prefetch queue,
// with redirect flush, stale-response discard and halt on bus fault.
module ifu_prefetch_axi
  import ifu_pkg::*;
#(
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 32,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = ADDR_W + DATA_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  ifu_state_e        state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] redirect_target;
  logic              stale;
  logic [CW-1:0]     count;
  logic [EW-1:0]     head;
  logic [EW-1:0]     push_entry;
  logic              ar_done;
  logic              r_done;
  logic              push;
  logic              pop;
  logic              slot_free;

  assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign ar_done         = arvalid & arready;
  assign r_done          = rvalid & rready;
  assign slot_free       = count < DEPTH_C;

  // araddr is held after the AR handshake, so it still names the in-flight word.
  assign push_entry = {araddr, rdata, resp_is_fault(rresp)};
  assign push       = r_done & ~stale;
  assign pop        = inst_valid & inst_ready;

  assign inst_valid = count != '0;
  assign inst       = inst_valid ? head[DATA_W:1] : '0;
  assign inst_pc    = inst_valid ? head[EW-1 -: ADDR_W] : '0;
  assign inst_fault = inst_valid & head[0];

  ifu_fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_entry),
    .count (count),
    .head  (head)
  );

  // Fetch FSM with registered AXI outputs, fetch PC and stale-response tracking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      stale    <= 1'b0;
      araddr   <= RESET_PC;
      arvalid  <= 1'b0;
      rready   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!redirect_valid && slot_free) begin
            state   <= ADDR;
            araddr  <= fetch_pc;
            arvalid <= 1'b1;
          end
        end
        ADDR: begin
          if (ar_done) begin
            state   <= DATA;
            arvalid <= 1'b0;
            rready  <= 1'b1;
            if (!stale) fetch_pc <= fetch_pc + ADDR_W'(4);
          end
        end
        DATA: begin
          if (r_done) begin
            rready <= 1'b0;
            if (!stale && !redirect_valid && resp_is_fault(rresp)) state <= HALT;
            else state <= IDLE;
          end
        end
        HALT: begin
          if (redirect_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Only one transaction can be outstanding, so its completion always ends staleness.
      if (r_done) stale <= 1'b0;
      else if (redirect_valid && (state == ADDR || state == DATA)) stale <= 1'b1;

      // A redirect overrides any increment made by the AR handshake above.
      if (redirect_valid) fetch_pc <= redirect_target;
    end
  end

endmodule
